// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE feed controller.
// State encoding, default widths and the operand-row lane slicer.
package pe_ctrl_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 8;
    localparam int STEP_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 16;
    localparam int LANES       = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_FINISH,
        S_WAIT,
        S_HOLD
    } state_t;

    // Low bit of lane `lane` inside a packed row of `w`-bit lanes.
    function automatic int unsigned lane_lo(
        input int unsigned lane,
        input int unsigned w
    );
        return lane * w;
    endfunction

endpackage

// File: rtl/pe_addr_gen.sv
// Row step counter plus base+offset address adder.
// One counter serves both buffers; only the latched bases differ.
module pe_addr_gen
    import pe_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [STEP_W-1:0] steps,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] w_base,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              last
);

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] steps_q;
    logic [ADDR_W-1:0] ifm_base_q;
    logic [ADDR_W-1:0] w_base_q;
    logic [ADDR_W-1:0] offset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q     <= '0;
            steps_q    <= '0;
            ifm_base_q <= '0;
            w_base_q   <= '0;
        end else if (load) begin
            step_q     <= '0;
            steps_q    <= steps;
            ifm_base_q <= ifm_base;
            w_base_q   <= w_base;
        end else if (inc) begin
            step_q <= step_q + STEP_W'(1);
        end
    end

    // Addresses wrap naturally at 2^ADDR_W.
    assign offset   = ADDR_W'(step_q);
    assign ifm_addr = ifm_base_q + offset;
    assign w_addr   = w_base_q + offset;
    assign last     = (step_q == steps_q - STEP_W'(1));

endmodule

// File: rtl/pe_feed_ctrl.sv
// Sequences one PE result: clear, stream operand rows, finish,
// then wait for the PE result and hold it for downstream.
module pe_feed_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int STEP_W  = STEP_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [STEP_W-1:0]     cfg_steps,
    input  logic [ADDR_W-1:0]     cfg_ifm_base,
    input  logic [ADDR_W-1:0]     cfg_w_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ifm_rd_en,
    output logic [ADDR_W-1:0]     ifm_rd_addr,
    input  logic [3*DATA_W-1:0]   ifm_rd_data,
    output logic                  w_rd_en,
    output logic [ADDR_W-1:0]     w_rd_addr,
    input  logic [3*DATA_W-1:0]   w_rd_data,
    output logic [DATA_W-1:0]     IFM1,
    output logic [DATA_W-1:0]     IFM2,
    output logic [DATA_W-1:0]     IFM3,
    output logic [DATA_W-1:0]     Weight1,
    output logic [DATA_W-1:0]     Weight2,
    output logic [DATA_W-1:0]     Weight3,
    output logic                  PE_en,
    output logic                  PE_finish,
    input  logic [DATA_W-1:0]     OFM,
    input  logic                  valid,
    output logic [DATA_W-1:0]     ofm_data,
    output logic                  ofm_valid,
    input  logic                  ofm_ready
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state;
    logic            rd_en;
    logic            feed_vld;
    logic            load;
    logic            inc;
    logic            last;
    logic [TO_W-1:0] to_cnt;

    assign load = (state == S_IDLE) && start && (cfg_steps != '0);
    assign inc  = ((state == S_CLEAR) || (state == S_FEED)) && !last;

    assign ifm_rd_en = rd_en;
    assign w_rd_en   = rd_en;

    pe_addr_gen #(
        .ADDR_W (ADDR_W),
        .STEP_W (STEP_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .inc      (inc),
        .steps    (cfg_steps),
        .ifm_base (cfg_ifm_base),
        .w_base   (cfg_w_base),
        .ifm_addr (ifm_rd_addr),
        .w_addr   (w_rd_addr),
        .last     (last)
    );

    // Buffer data lands one cycle after the read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            feed_vld <= 1'b0;
        end else begin
            feed_vld <= rd_en;
        end
    end

    // The PE accumulates every cycle it is not cleared, so idle operands must be zero.
    always_comb begin
        IFM1    = '0;
        IFM2    = '0;
        IFM3    = '0;
        Weight1 = '0;
        Weight2 = '0;
        Weight3 = '0;
        if (feed_vld) begin
            IFM1    = ifm_rd_data[lane_lo(0, DATA_W) +: DATA_W];
            IFM2    = ifm_rd_data[lane_lo(1, DATA_W) +: DATA_W];
            IFM3    = ifm_rd_data[lane_lo(2, DATA_W) +: DATA_W];
            Weight1 = w_rd_data[lane_lo(0, DATA_W) +: DATA_W];
            Weight2 = w_rd_data[lane_lo(1, DATA_W) +: DATA_W];
            Weight3 = w_rd_data[lane_lo(2, DATA_W) +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            PE_en     <= 1'b0;
            PE_finish <= 1'b0;
            ofm_valid <= 1'b0;
            ofm_data  <= '0;
            to_cnt    <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            PE_en     <= 1'b0;
            PE_finish <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_steps != '0) begin
                            state <= S_CLEAR;
                            busy  <= 1'b1;
                            PE_en <= 1'b1;
                            rd_en <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (last) begin
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        state <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (last) begin
                        rd_en <= 1'b0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    PE_finish <= 1'b1;
                    state     <= S_FINISH;
                end
                S_FINISH: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (valid) begin
                        ofm_data  <= OFM;
                        ofm_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_HOLD: begin
                    if (ofm_ready) begin
                        ofm_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Bench for pe_feed_ctrl with a behavioural PE and two 1-cycle ROMs.
// A transaction-level model predicts each cycle of a launched job.
module tb_pe_feed_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int SW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [SW-1:0] cfg_steps;
    logic [AW-1:0] cfg_ifm_base;
    logic [AW-1:0] cfg_w_base;
    logic          busy, done, err;
    logic          ifm_rd_en, w_rd_en;
    logic [AW-1:0] ifm_rd_addr, w_rd_addr;
    logic [23:0]   ifm_rd_data, w_rd_data;
    logic [DW-1:0] IFM1, IFM2, IFM3;
    logic [DW-1:0] Weight1, Weight2, Weight3;
    logic          PE_en, PE_finish;
    logic [DW-1:0] OFM;
    logic          valid;
    logic [DW-1:0] ofm_data;
    logic          ofm_valid;
    logic          ofm_ready;

    always #5 clk = ~clk;

    pe_feed_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .STEP_W  (SW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_steps    (cfg_steps),
        .cfg_ifm_base (cfg_ifm_base),
        .cfg_w_base   (cfg_w_base),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ifm_rd_en    (ifm_rd_en),
        .ifm_rd_addr  (ifm_rd_addr),
        .ifm_rd_data  (ifm_rd_data),
        .w_rd_en      (w_rd_en),
        .w_rd_addr    (w_rd_addr),
        .w_rd_data    (w_rd_data),
        .IFM1         (IFM1),
        .IFM2         (IFM2),
        .IFM3         (IFM3),
        .Weight1      (Weight1),
        .Weight2      (Weight2),
        .Weight3      (Weight3),
        .PE_en        (PE_en),
        .PE_finish    (PE_finish),
        .OFM          (OFM),
        .valid        (valid),
        .ofm_data     (ofm_data),
        .ofm_valid    (ofm_valid),
        .ofm_ready    (ofm_ready)
    );

    logic [23:0] ifm_mem [256];
    logic [23:0] w_mem   [256];

    always @(posedge clk) begin
        if (ifm_rd_en) ifm_rd_data <= ifm_mem[ifm_rd_addr];
        if (w_rd_en)   w_rd_data   <= w_mem[w_rd_addr];
    end

    // Behavioural PE: clear on PE_en, accumulate otherwise, answer 1 cycle after finish.
    logic [31:0] acc = 32'd0;
    logic        pe_silent;

    always @(posedge clk) begin
        valid <= 1'b0;
        if (PE_en) acc <= 32'd0;
        else acc <= acc + IFM1 * Weight1 + IFM2 * Weight2 + IFM3 * Weight3;
        if (PE_finish && !pe_silent) begin
            valid <= 1'b1;
            OFM   <= acc[7:0];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0;
    int done_cyc = -1, err_cyc = -1;
    int pe_en_cyc = -1, pe_fin_cyc = -1;
    logic [AW-1:0] addr_log [$];

    bit            tx_on;
    int            tx_t0;
    int            tx_n;
    logic [AW-1:0] tx_ib;
    logic [AW-1:0] tx_wb;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_result(input int n,
                                              input logic [AW-1:0] ib,
                                              input logic [AW-1:0] wb);
        int sum = 0;
        for (int r = 0; r < n; r++) begin
            logic [AW-1:0] ia = ib + AW'(r);
            logic [AW-1:0] wa = wb + AW'(r);
            for (int l = 0; l < 3; l++)
                sum += int'(ifm_mem[ia][8*l +: 8]) * int'(w_mem[wa][8*l +: 8]);
        end
        return sum[7:0];
    endfunction

    // Advance one cycle, sample at the falling edge, and compare against the model.
    task automatic tick();
        int k;
        bit win, feed, e_rd;
        logic [AW-1:0] ea, ra, wa;
        @(negedge clk);
        cyc++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err) begin err_cnt++; err_cyc = cyc; end
        if (PE_en) pe_en_cyc = cyc;
        if (PE_finish) pe_fin_cyc = cyc;
        if (ifm_rd_en) addr_log.push_back(ifm_rd_addr);
        k    = cyc - tx_t0;
        win  = tx_on && k >= 1 && k <= tx_n + 2;
        feed = win && k >= 2 && k <= tx_n + 1;
        e_rd = win && k <= tx_n;
        chk("pe_en", 32'(PE_en), 32'(win && k == 1));
        chk("pe_finish", 32'(PE_finish), 32'(win && k == tx_n + 2));
        chk("ifm_rd_en", 32'(ifm_rd_en), 32'(e_rd));
        chk("w_rd_en", 32'(w_rd_en), 32'(e_rd));
        if (e_rd) begin
            ea = tx_ib + AW'(k - 1);
            chk("ifm_addr", 32'(ifm_rd_addr), 32'(ea));
            ea = tx_wb + AW'(k - 1);
            chk("w_addr", 32'(w_rd_addr), 32'(ea));
        end
        if (feed) begin
            ra = tx_ib + AW'(k - 2);
            wa = tx_wb + AW'(k - 2);
            chk("ifm_row", 32'({IFM3, IFM2, IFM1}), 32'(ifm_mem[ra]));
            chk("w_row", 32'({Weight3, Weight2, Weight1}), 32'(w_mem[wa]));
        end else begin
            chk("ifm_zero", 32'({IFM3, IFM2, IFM1}), 32'd0);
            chk("w_zero", 32'({Weight3, Weight2, Weight1}), 32'd0);
        end
        if (win) chk("busy_on", 32'(busy), 32'd1);
        if (!tx_on) begin
            chk("busy_off", 32'(busy), 32'd0);
            chk("ofm_valid_idle", 32'(ofm_valid), 32'd0);
        end
        if (tx_on && (done || err)) tx_on = 1'b0;
    endtask

    task automatic launch(input int n, input logic [AW-1:0] ib,
                          input logic [AW-1:0] wb);
        start        = 1'b1;
        cfg_steps    = SW'(n);
        cfg_ifm_base = ib;
        cfg_w_base   = wb;
        tx_t0 = cyc;
        tx_n  = n;
        tx_ib = ib;
        tx_wb = wb;
        tx_on = (n != 0);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ofm(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ofm_valid) begin
                at = cyc;
                break;
            end
        end
        chk("ofm_valid_seen", 32'(at >= 0), 32'd1);
    endtask

    initial begin
        int at, d0, e0;
        for (int i = 0; i < 256; i++) begin
            ifm_mem[i] = 24'd0;
            w_mem[i]   = 24'd0;
        end
        ifm_mem[8'h10] = {8'd5, 8'd4, 8'd3};
        ifm_mem[8'h11] = {8'd3, 8'd2, 8'd1};
        w_mem[8'h20]   = {8'd3, 8'd1, 8'd2};
        w_mem[8'h21]   = {8'd1, 8'd3, 8'd2};
        ifm_mem[8'h30] = {8'd30, 8'd20, 8'd10};
        w_mem[8'h40]   = {8'd1, 8'd1, 8'd1};
        ifm_mem[8'd254] = {8'd1, 8'd1, 8'd1};
        ifm_mem[8'd255] = {8'd2, 8'd2, 8'd2};
        ifm_mem[8'd0]   = {8'd3, 8'd3, 8'd3};
        w_mem[8'd254]   = {8'd3, 8'd2, 8'd1};
        w_mem[8'd255]   = {8'd1, 8'd1, 8'd1};
        w_mem[8'd0]     = {8'd1, 8'd0, 8'd2};

        reset = 1'b1;
        start = 1'b0;
        cfg_steps = '0;
        cfg_ifm_base = '0;
        cfg_w_base = '0;
        ofm_ready = 1'b0;
        pe_silent = 1'b0;
        tx_on = 1'b0;
        tx_t0 = 0;
        tx_n = 0;
        tx_ib = '0;
        tx_wb = '0;
        repeat (3) tick();
        chk("rst_ofm_data", 32'(ofm_data), 32'd0);
        chk("rst_ifm_addr", 32'(ifm_rd_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        // Two-row dot product, downstream always ready
        ofm_ready = 1'b1;
        d0 = done_cnt;
        launch(2, 8'h10, 8'h20);
        wait_ofm(at);
        chk("t1_latency", 32'(at - tx_t0), 32'd6);
        chk("t1_model", 32'(ofm_data), 32'(exp_result(2, 8'h10, 8'h20)));
        chk("t1_ofm", 32'(ofm_data), 32'd36);
        repeat (4) tick();
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_done_cyc", 32'(done_cyc - at), 32'd1);

        // Single row
        launch(1, 8'h30, 8'h40);
        wait_ofm(at);
        chk("t2_ofm", 32'(ofm_data), 32'd60);
        chk("t2_latency", 32'(at - tx_t0), 32'd5);
        chk("t2_pe_en_cyc", 32'(pe_en_cyc - tx_t0), 32'd1);
        chk("t2_pe_fin_cyc", 32'(pe_fin_cyc - tx_t0), 32'd3);
        repeat (3) tick();

        // Backpressure hold with ignored start pulses
        ofm_ready = 1'b0;
        d0 = done_cnt;
        launch(2, 8'h10, 8'h20);
        wait_ofm(at);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", 32'(ofm_valid), 32'd1);
            chk("t3_hold_data", 32'(ofm_data), 32'd36);
            start = (i == 1 || i == 3);
            cfg_steps = SW'(1);
        end
        start = 1'b0;
        ofm_ready = 1'b1;
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_valid_drop", 32'(ofm_valid), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Zero-step start
        e0 = err_cnt;
        launch(0, 8'h10, 8'h20);
        chk("t4_err_cyc", 32'(err_cyc - tx_t0), 32'd1);
        repeat (3) tick();
        chk("t4_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        // Silent PE
        pe_silent = 1'b1;
        e0 = err_cnt;
        d0 = done_cnt;
        launch(1, 8'h30, 8'h40);
        repeat (25) tick();
        chk("t5_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("t5_err_cyc", 32'(err_cyc - tx_t0), 32'(1 + 3 + TO));
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        pe_silent = 1'b0;

        // Address wrap, reset mid-feed, then a clean rerun
        launch(3, 8'd254, 8'd254);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rd_en", 32'(ifm_rd_en), 32'd0);
        chk("t6_rst_addr", 32'(ifm_rd_addr), 32'd0);
        chk("t6_rst_waddr", 32'(w_rd_addr), 32'd0);
        chk("t6_rst_ops", 32'({IFM3, IFM2, IFM1}), 32'd0);
        chk("t6_rst_pe_en", 32'(PE_en), 32'd0);
        tx_on = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        addr_log.delete();
        launch(3, 8'd254, 8'd254);
        wait_ofm(at);
        chk("t6_model", 32'(ofm_data), 32'(exp_result(3, 8'd254, 8'd254)));
        chk("t6_ofm", 32'(ofm_data), 32'd21);
        chk("t6_addr_n", 32'(addr_log.size()), 32'd3);
        if (addr_log.size() == 3) begin
            chk("t6_addr0", 32'(addr_log[0]), 32'd254);
            chk("t6_addr1", 32'(addr_log[1]), 32'd255);
            chk("t6_addr2", 32'(addr_log[2]), 32'd0);
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
